mem_agu_pipe: RTL
=================

Name: mem_agu_pipe

Overview:
- Parameterised, pipelined load/store address generation unit between the decode/execute stage and the data memory port.
- Computes the effective address as base plus a sign-extended immediate offset.
- Produces a lane-aligned address, byte enables and lane-shifted store data.
- Misaligned accesses either split into two aligned beats or are flagged as errors. Input and output use valid/ready handshakes, with one registered output stage.

Parameters:
- XLEN, 32, datapath and address width; must be 32 or 64.
- OFF_W, 12, offset width; offset is sign-extended to XLEN.
- SPLIT_MISALIGNED, 1, 1 = split a lane-crossing access into two beats; 0 = flag it as an error.
- Derived: BYTES = XLEN/8; LB = log2(BYTES).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready at clk edge
- in_base  input  XLEN  base register value
- in_offset  input  OFF_W  signed immediate
- in_size  input  2  access size: 2^in_size bytes
- in_store  input  1  1 = store, 0 = load
- in_wdata  input  XLEN  store data, right-justified
- out_valid  output  1  beat valid
- out_ready  input  1  beat consumed when out_valid && out_ready
- out_addr  output  XLEN  lane-aligned address (low LB bits zero)
- out_be  output  BYTES  byte enables
- out_wdata  output  XLEN  store data shifted to lanes
- out_store  output  1  copy of in_store
- out_last  output  1  final beat of request
- out_err  output  1  illegal or unsplit misaligned access; out_be = 0
- out_lane  output  LB  ea[LB-1:0], for load-data realignment

Behaviour:
- Arithmetic:
  - ea = in_base + sext(in_offset), modulo 2^XLEN, carry discarded.
  - lane = ea[LB-1:0].
  - m = ((1<<(1<<in_size))-1) << lane, computed at 2*BYTES width.
  - w = zext(in_wdata) << (lane*8), computed at 2*XLEN width.
  - A = ea with low LB bits cleared.
- Illegal size: 2^in_size > BYTES (in_size=3 when XLEN=32). Result is one beat with out_err=1, out_be=0, out_last=1, out_addr=A.
- Aligned: m[2B-1:B]==0. One beat: out_addr=A, out_be=m[B-1:0], out_wdata=w[XLEN-1:0], out_last=1, out_err=0.
- Misaligned, SPLIT_MISALIGNED=1, two beats:
  - Beat 0: out_addr=A, out_be=m[B-1:0], out_wdata=w low, out_last=0.
  - Beat 1: out_addr=A+BYTES (wraps to 0 past top of memory), out_be=m[2B-1:B], out_wdata=w high, out_last=1.
- Misaligned, SPLIT_MISALIGNED=0: one beat with out_err=1, out_be=0, out_last=1.
- out_store and out_lane are identical on both beats of a request.
- FSM states:
  - EMPTY: no beat held.
  - ONE: single-beat request held.
  - S0: first of two beats held; second-beat data registered internally.
  - S1: second beat held.
- Transitions:
  - EMPTY, accept -> ONE or S0.
  - ONE or S1, out_ready: accept -> ONE or S0; no accept -> EMPTY.
  - S0, out_ready -> S1.
  - Any state without out_ready: hold state.
- in_ready = (state==EMPTY) || ((state==ONE || state==S1) && out_ready).
  - in_ready is 0 in S0.
  - in_ready is combinational from out_ready; there is no path from in_valid to in_ready.
- Latency and throughput:
  - Request accepted at edge N is presented at N+1 (out_valid=1).
  - Aligned requests sustain one per cycle.
  - Split requests take 2 cycles and insert one input bubble.
- Stability: while out_valid && !out_ready, all out_* outputs hold constant.
- Reset (async assert, sync deassert by system):
  - State EMPTY; out_valid=0.
  - out_addr, out_be, out_wdata, out_store, out_last, out_err and out_lane all 0.
  - in_ready=1 after release.
  - Reset during S0/S1 discards the pending beat; no beat 1 is issued afterwards.
- out_valid is driven only from state, never combinationally from in_valid.

Test Plan:
- XLEN=32: base=0x00001000, offset=0xFFC, size=2, load, out_ready=1 -> next cycle out_addr=0x00000FFC, be=4'b1111, last=1, err=0, lane=0.
- Store half: base=0x00001001, offset=0x002, size=1, wdata=0x0000ABCD -> beat0 addr=0x1000, be=4'b1000, wdata[31:24]=0xCD, last=0; beat1 addr=0x1004, be=4'b0001, wdata[7:0]=0xAB, last=1; in_ready=0 during beat0.
- Wrap: base=0xFFFFFFFE, offset=0x000, size=2 -> beat0 addr=0xFFFFFFFC, be=4'b1100; beat1 addr=0x00000000, be=4'b0011.
- Back-pressure: out_ready=0 for 5 cycles with in_valid held high -> outputs stable, in_ready=0, exactly one request consumed; then 4 back-to-back aligned requests complete in 4 consecutive cycles.
- SPLIT_MISALIGNED=0: size=2 at ea=0x1002 -> single beat err=1, be=0, last=1. Also size=3 with XLEN=32 -> err=1.
- Reset: assert rst_n=0 while in S0 -> out_valid drops immediately; after release no beat 1 appears and in_ready=1.

Source files
------------

// File: rtl/mem_agu_pipe.sv
// Load/store address generation unit with one registered output stage.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           request handshake
//   in_base, in_offset          base register, signed immediate offset
//   in_size, in_store, in_wdata 2^size bytes, store flag, right-justified data
//   out_valid/out_ready         beat handshake
//   out_addr, out_be, out_wdata lane-aligned address, byte enables, lane data
//   out_store, out_last         store flag, final beat of the request
//   out_err, out_lane           illegal/unsplit access, ea low bits
module mem_agu_pipe #(
    parameter int XLEN             = 32,
    parameter int OFF_W            = 12,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_base,
    input  logic [OFF_W-1:0]         in_offset,
    input  logic [1:0]               in_size,
    input  logic                     in_store,
    input  logic [XLEN-1:0]          in_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_addr,
    output logic [XLEN/8-1:0]        out_be,
    output logic [XLEN-1:0]          out_wdata,
    output logic                     out_store,
    output logic                     out_last,
    output logic                     out_err,
    output logic [$clog2(XLEN/8)-1:0] out_lane
);

    localparam int BYTES = XLEN / 8;
    localparam int LB    = $clog2(BYTES);

    localparam logic [2*BYTES-1:0] ONE_M   = 1;
    localparam logic [3:0]         BYTES_N = 4'(BYTES);
    localparam logic [XLEN-1:0]    BSTEP   = XLEN'(BYTES);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        S0    = 2'd2,
        S1    = 2'd3
    } state_e;

    state_e state_q;

    logic [XLEN-1:0]    addr_q,  addr1_q;
    logic [BYTES-1:0]   be_q,    be1_q;
    logic [XLEN-1:0]    wdata_q, wdata1_q;
    logic               store_q, last_q, err_q;
    logic [LB-1:0]      lane_q;

    logic [XLEN-1:0]    ea;
    logic [XLEN-1:0]    a_d;
    logic [LB-1:0]      lane_d;
    logic [3:0]         nbytes;
    logic [2*BYTES-1:0] m_d;
    logic [2*XLEN-1:0]  w_d;
    logic               illegal, misal, accept;

    assign ea     = in_base + {{(XLEN-OFF_W){in_offset[OFF_W-1]}}, in_offset};
    assign lane_d = ea[LB-1:0];
    assign a_d    = {ea[XLEN-1:LB], {LB{1'b0}}};
    assign nbytes = 4'd1 << in_size;

    // Mask and data are built at double width so a lane-crossing access
    // naturally spills its upper part into the second beat.
    assign m_d     = ((ONE_M << nbytes) - ONE_M) << lane_d;
    assign w_d     = {{XLEN{1'b0}}, in_wdata} << {lane_d, 3'b000};
    assign illegal = nbytes > BYTES_N;
    assign misal   = !illegal && (|m_d[2*BYTES-1:BYTES]);

    assign in_ready = (state_q == EMPTY) ||
                      (((state_q == ONE) || (state_q == S1)) && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            lane_q   <= '0;
            addr1_q  <= '0;
            be1_q    <= '0;
            wdata1_q <= '0;
        end else begin
            unique case (state_q)
                EMPTY, ONE, S1: begin
                    if (accept) begin
                        addr_q  <= a_d;
                        wdata_q <= w_d[XLEN-1:0];
                        store_q <= in_store;
                        lane_q  <= lane_d;
                        if (illegal || (misal && !SPLIT_MISALIGNED)) begin
                            be_q    <= '0;
                            last_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= ONE;
                        end else if (misal) begin
                            be_q     <= m_d[BYTES-1:0];
                            last_q   <= 1'b0;
                            err_q    <= 1'b0;
                            addr1_q  <= a_d + BSTEP;
                            be1_q    <= m_d[2*BYTES-1:BYTES];
                            wdata1_q <= w_d[2*XLEN-1:XLEN];
                            state_q  <= S0;
                        end else begin
                            be_q    <= m_d[BYTES-1:0];
                            last_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state_q <= ONE;
                        end
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                S0: begin
                    if (out_ready) begin
                        addr_q  <= addr1_q;
                        be_q    <= be1_q;
                        wdata_q <= wdata1_q;
                        last_q  <= 1'b1;
                        state_q <= S1;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign out_addr  = addr_q;
    assign out_be    = be_q;
    assign out_wdata = wdata_q;
    assign out_store = store_q;
    assign out_last  = last_q;
    assign out_err   = err_q;
    assign out_lane  = lane_q;

endmodule
